// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the ROM byte address and hands registered words to decode over valid/ready.
// Optional EBREAK halt is enabled by defining FETCH_EBREAK_HALT_EN.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  output logic [ADDR_WIDTH-1:0] rom_addr_out,
  input  logic [DATA_WIDTH-1:0] rom_data_in,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  input  logic                  redirect_in,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
  output logic                  fault_out,
  output logic                  halted_out
);

`ifdef FETCH_EBREAK_HALT_EN
  typedef enum logic [1:0] {ST_RUN, ST_FAULT, ST_HALT} state_t;
  localparam logic [DATA_WIDTH-1:0] EBREAK = DATA_WIDTH'(32'h0010_0073);
  logic halted_q;
`else
  typedef enum logic [0:0] {ST_RUN, ST_FAULT} state_t;
`endif

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_out_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  valid_q;
  logic                  fault_q;
  logic                  target_aligned;

  assign target_aligned = (redirect_pc_in[1:0] == 2'b00);

  // NOTE: all state lives in one clocked block using non-blocking assignments, and reset is
  // synchronous, so every register (including the instruction word) is cleared on a clock edge.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
`ifdef FETCH_EBREAK_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_RUN: begin
          if (redirect_in) begin
            // The held instruction is dropped even if decode is taking it this edge.
            valid_q <= 1'b0;
            if (target_aligned) begin
              pc_q <= redirect_pc_in;
            end else begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end
          end else if (!valid_q || ready_in) begin
`ifdef FETCH_EBREAK_HALT_EN
            if (valid_q && (instr_q == EBREAK)) begin
              // EBREAK is being consumed; pc_q already points past it.
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end else
`endif
            begin
              instr_q  <= rom_data_in;
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
              pc_q     <= pc_q + ADDR_WIDTH'(4);
            end
          end
          // Stall (valid with no ready): everything holds.
        end
        ST_FAULT: begin
          if (redirect_in && target_aligned) begin
            fault_q <= 1'b0;
            pc_q    <= redirect_pc_in;
            state_q <= ST_RUN;
          end
        end
`ifdef FETCH_EBREAK_HALT_EN
        ST_HALT: begin
          if (redirect_in && target_aligned) begin
            halted_q <= 1'b0;
            pc_q     <= redirect_pc_in;
            state_q  <= ST_RUN;
          end
        end
`endif
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign rom_addr_out = pc_q;
  assign instr_out    = instr_q;
  assign pc_out       = pc_out_q;
  assign valid_out    = valid_q;
  assign fault_out    = fault_q;
`ifdef FETCH_EBREAK_HALT_EN
  assign halted_out   = halted_q;
`else
  assign halted_out   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: expected fetch PCs are queued per scenario and
// compared against each observed valid/ready transfer.
module tb_instr_fetch_unit;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        ebreak_mode = 1'b0;

  logic [15:0] rom_addr, pc_out;
  logic [31:0] rom_data, instr_out;
  logic        valid, fault, halted;

  logic        rst_w = 1'b0;
  logic [15:0] rom_addr_w, pc_out_w;
  logic [31:0] rom_data_w, instr_out_w;
  logic        valid_w, fault_w, halted_w;

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_pc;

  always #5 clk = ~clk;

  // ROM model: a distinct word per address, with an EBREAK at 0x8 when requested.
  function automatic logic [31:0] model_rom(input logic [15:0] a);
    if (ebreak_mode && a == 16'h0008) return EBREAK_WORD;
    return {a ^ 16'h5A5A, a};
  endfunction

  assign rom_data   = model_rom(rom_addr);
  assign rom_data_w = model_rom(rom_addr_w);

  instr_fetch_unit u_dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .rom_addr_out  (rom_addr),
    .rom_data_in   (rom_data),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .valid_out     (valid),
    .ready_in      (ready),
    .redirect_in   (redirect),
    .redirect_pc_in(redirect_pc),
    .fault_out     (fault),
    .halted_out    (halted)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFF8)) u_wrap (
    .clk_in        (clk),
    .rst_n_in      (rst_w),
    .rom_addr_out  (rom_addr_w),
    .rom_data_in   (rom_data_w),
    .instr_out     (instr_out_w),
    .pc_out        (pc_out_w),
    .valid_out     (valid_w),
    .ready_in      (1'b1),
    .redirect_in   (1'b0),
    .redirect_pc_in(16'h0000),
    .fault_out     (fault_w),
    .halted_out    (halted_w)
  );

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b0; redirect = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid); else pass_cnt++;
    total_cnt++; if ({instr_out, pc_out} !== 48'h0) $display("FAIL reset_data: got %h/%h want 0/0", instr_out, pc_out); else pass_cnt++;
    total_cnt++; if ({fault, halted} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {fault, halted}); else pass_cnt++;
    total_cnt++; if (rom_addr !== 16'h0000) $display("FAIL reset_rom_addr: got %h want 0000", rom_addr); else pass_cnt++;
    rst_n = 1'b1; ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (valid !== 1'b1 || pc_out !== 16'h0000 || instr_out !== model_rom(16'h0000))
      $display("FAIL first_fetch: got v=%0b pc=%h ins=%h want v=1 pc=0000 ins=%h", valid, pc_out, instr_out, model_rom(16'h0000));
    else pass_cnt++;
    total_cnt++; if (rom_addr !== 16'h0004) $display("FAIL first_rom_addr: got %h want 0004", rom_addr); else pass_cnt++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ready = 1'b0;
      total_cnt++;
      if (valid !== 1'b1 || pc_out !== 16'h0004 || instr_out !== model_rom(16'h0004) || rom_addr !== 16'h0008)
        $display("FAIL stall_hold[%0d]: got v=%0b pc=%h ins=%h rom=%h want v=1 pc=0004 ins=%h rom=0008",
                 i, valid, pc_out, instr_out, rom_addr, model_rom(16'h0004));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(16'h0004);
    exp_q.push_back(16'h0008);
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      ready = 1'b1;
      if (valid) begin
        exp_pc = exp_q.pop_front();
        total_cnt++;
        if (pc_out !== exp_pc || instr_out !== model_rom(exp_pc))
          $display("FAIL b2b_transfer: got pc=%h ins=%h want pc=%h ins=%h", pc_out, instr_out, exp_pc, model_rom(exp_pc));
        else pass_cnt++;
      end
    end
    if (exp_q.size() != 0) begin total_cnt++; $display("FAIL b2b_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_redirect();
    @(negedge clk);
    total_cnt++; if (valid !== 1'b1 || pc_out !== 16'h000C) $display("FAIL redir_pre: got v=%0b pc=%h want v=1 pc=000c", valid, pc_out); else pass_cnt++;
    redirect = 1'b1; redirect_pc = 16'h0014; ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    total_cnt++; if (valid !== 1'b0 || rom_addr !== 16'h0014) $display("FAIL redir_bubble: got v=%0b rom=%h want v=0 rom=0014", valid, rom_addr); else pass_cnt++;
    exp_q.push_back(16'h0014);
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      ready = 1'b1;
      if (valid) begin
        exp_pc = exp_q.pop_front();
        total_cnt++;
        if (pc_out !== exp_pc || instr_out !== model_rom(exp_pc))
          $display("FAIL redir_target: got pc=%h ins=%h want pc=%h ins=%h", pc_out, instr_out, exp_pc, model_rom(exp_pc));
        else pass_cnt++;
      end
    end
    if (exp_q.size() != 0) begin total_cnt++; $display("FAIL redir_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_fault();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h0016;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      redirect = 1'b0; ready = i[0];
      total_cnt++;
      if (fault !== 1'b1 || valid !== 1'b0 || rom_addr !== 16'h001C)
        $display("FAIL fault_hold[%0d]: got f=%0b v=%0b rom=%h want f=1 v=0 rom=001c", i, fault, valid, rom_addr);
      else pass_cnt++;
    end
    redirect = 1'b1; redirect_pc = 16'h001A;
    @(negedge clk);
    total_cnt++; if (fault !== 1'b1 || rom_addr !== 16'h001C) $display("FAIL fault_misaligned_again: got f=%0b rom=%h want f=1 rom=001c", fault, rom_addr); else pass_cnt++;
    redirect = 1'b1; redirect_pc = 16'h0018;
    @(negedge clk);
    redirect = 1'b0; ready = 1'b1;
    total_cnt++; if (fault !== 1'b0 || valid !== 1'b0 || rom_addr !== 16'h0018)
      $display("FAIL fault_exit: got f=%0b v=%0b rom=%h want f=0 v=0 rom=0018", fault, valid, rom_addr);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (valid !== 1'b1 || pc_out !== 16'h0018 || instr_out !== model_rom(16'h0018))
      $display("FAIL fault_resume: got v=%0b pc=%h ins=%h want v=1 pc=0018 ins=%h", valid, pc_out, instr_out, model_rom(16'h0018));
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst_w = 1'b0;
    @(negedge clk);
    total_cnt++; if (rom_addr_w !== 16'hFFF8 || valid_w !== 1'b0) $display("FAIL wrap_reset: got rom=%h v=%0b want rom=fff8 v=0", rom_addr_w, valid_w); else pass_cnt++;
    rst_w = 1'b1;
    exp_q.push_back(16'hFFF8);
    exp_q.push_back(16'hFFFC);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0004);
    for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (valid_w) begin
        exp_pc = exp_q.pop_front();
        total_cnt++;
        if (pc_out_w !== exp_pc || instr_out_w !== model_rom(exp_pc))
          $display("FAIL wrap_seq: got pc=%h ins=%h want pc=%h ins=%h", pc_out_w, instr_out_w, exp_pc, model_rom(exp_pc));
        else pass_cnt++;
      end
    end
    if (exp_q.size() != 0) begin total_cnt++; $display("FAIL wrap_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_ebreak();
    ebreak_mode = 1'b1; rst_n = 1'b0; ready = 1'b1; redirect = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0004);
    exp_q.push_back(16'h0008);
`ifndef FETCH_EBREAK_HALT_EN
    exp_q.push_back(16'h000C);
`endif
    for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      ready = 1'b1;
      if (valid) begin
        exp_pc = exp_q.pop_front();
        total_cnt++;
        if (pc_out !== exp_pc || instr_out !== model_rom(exp_pc))
          $display("FAIL ebreak_seq: got pc=%h ins=%h want pc=%h ins=%h", pc_out, instr_out, exp_pc, model_rom(exp_pc));
        else pass_cnt++;
      end
    end
    if (exp_q.size() != 0) begin total_cnt++; $display("FAIL ebreak_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
`ifdef FETCH_EBREAK_HALT_EN
    total_cnt++; if (valid !== 1'b0 || halted !== 1'b1 || rom_addr !== 16'h000C)
      $display("FAIL ebreak_halt: got v=%0b h=%0b rom=%h want v=0 h=1 rom=000c", valid, halted, rom_addr);
    else pass_cnt++;
    redirect = 1'b1; redirect_pc = 16'h0000;
    @(negedge clk);
    redirect = 1'b0;
    total_cnt++; if (halted !== 1'b0 || valid !== 1'b0) $display("FAIL ebreak_exit: got h=%0b v=%0b want h=0 v=0", halted, valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (valid !== 1'b1 || pc_out !== 16'h0000) $display("FAIL ebreak_resume: got v=%0b pc=%h want v=1 pc=0000", valid, pc_out); else pass_cnt++;
`else
    total_cnt++; if (halted !== 1'b0 || valid !== 1'b1 || pc_out !== 16'h0010)
      $display("FAIL ebreak_ignored: got h=%0b v=%0b pc=%h want h=0 v=1 pc=0010", halted, valid, pc_out);
    else pass_cnt++;
`endif
    ebreak_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_back_to_back();
    test_redirect();
    test_fault();
    test_wrap();
    test_ebreak();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction ROM interface.
- Drives the byte address into the 2^14 x 32-bit instruction ROM, which has combinational read and a 16-bit byte address, always word-aligned.
- Registers the returned word and hands it to the decode stage over a valid/ready handshake.
- Supports PC redirect for branches and jumps, back-pressure stall, and misaligned-target fault.

Parameters:
- ADDR_WIDTH, 16, ROM byte-address width.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 16'h0000, first fetch address after reset; must be a multiple of 4.

Ports:
- clk_in  input  1  clock, rising-edge active.
- rst_n_in  input  1  synchronous active-low reset.
- rom_addr_out  output  ADDR_WIDTH  byte address to ROM; equals internal pc_q.
- rom_data_in  input  DATA_WIDTH  ROM read data for rom_addr_out, same cycle.
- instr_out  output  DATA_WIDTH  fetched instruction to decode.
- pc_out  output  ADDR_WIDTH  byte address of instr_out.
- valid_out  output  1  instr_out/pc_out hold a valid instruction.
- ready_in  input  1  decode accepts the instruction this cycle.
- redirect_in  input  1  branch/jump taken; flush and refetch.
- redirect_pc_in  input  ADDR_WIDTH  redirect target byte address.
- fault_out  output  1  misaligned redirect target; fetch stopped.
- halted_out  output  1  EBREAK halt (optional feature); constant 0 otherwise.

Behaviour:
- Reset, sampled on the clk_in edge while rst_n_in=0:
  - pc_q=RESET_PC; state=RUN.
  - valid_out=0, instr_out=0, pc_out=0, fault_out=0, halted_out=0.
- rom_addr_out = pc_q, driven from the register (no combinational path from inputs).
- State RUN, evaluated each edge in strict priority order:
  1. redirect_in=1:
     - valid_out<=0 (flush the held instruction, even if ready_in=1 that cycle).
     - If redirect_pc_in[1:0]==0: pc_q<=redirect_pc_in.
     - Else: state<=FAULT, fault_out<=1, pc_q unchanged.
  2. valid_out=1 and ready_in=0 (stall): all registers hold; rom_addr_out stays stable.
  3. Otherwise (valid_out=0, or valid_out=1 with ready_in=1):
     - instr_out<=rom_data_in; pc_out<=pc_q; valid_out<=1.
     - pc_q<=pc_q+4 modulo 2^ADDR_WIDTH, so 16'hFFFC wraps to 16'h0000.
- State FAULT:
  - valid_out=0, fault_out=1, pc_q frozen; ready_in ignored.
  - Leaves only on reset, or on redirect_in=1 with an aligned target: fault_out<=0, pc_q<=target, state<=RUN.
  - A misaligned redirect in FAULT stays in FAULT.
- Latency:
  - First valid_out=1 one cycle after rst_n_in deasserts.
  - Redirect to first valid instruction from the target: 2 cycles (one bubble).
  - Full throughput of one instruction per cycle while ready_in=1.
- Handshake rules:
  - A transfer occurs on an edge with valid_out=1 and ready_in=1.
  - instr_out/pc_out must not change while valid_out=1 and ready_in=0.
  - valid_out never drops without a transfer, except on redirect or reset.
- Reset mid-stall or mid-fault: synchronous reset overrides all; outputs return to reset values on that edge.
- Simultaneous redirect_in and ready_in: redirect wins; the held instruction counts as consumed or discarded, and no new instruction is registered that edge.

Optional Feature:
- Macro: FETCH_EBREAK_HALT_EN.
- Defined:
  - Adds state HALT.
  - When a word equal to 32'h00100073 (EBREAK) is registered into instr_out, state<=HALT after that word transfers.
  - In HALT: valid_out=0, halted_out=1, pc_q holds address of EBREAK+4.
  - Exit only via aligned redirect (halted_out<=0, RUN) or reset.
  - Redirect during the EBREAK's own stall cancels the halt.
- Not defined: EBREAK is fetched like any other word; halted_out tied to 0; no HALT state synthesized.

Test Plan:
- Reset release with ready_in=1 and ROM words W0..W3 at 0,4,8,12 -> rom_addr_out 0,4,8,12 in consecutive cycles; valid_out=1 from the cycle after release, pc_out 0,4,8 with matching data.
- Stall: ready_in=0 for 3 cycles while pc_out=4 -> instr_out, pc_out and rom_addr_out=8 stable; after ready_in=1, pc_out=8 next cycle with no loss or duplication.
- Redirect to 16'h0014 while valid_out=1 -> next cycle valid_out=0 and rom_addr_out=0x14; following cycle pc_out=0x14 with the word at 0x14.
- Redirect to 16'h0016 -> fault_out=1, valid_out=0 held 5 cycles regardless of ready_in; then redirect to 16'h0018 -> fault_out=0, pc_out=0x18 two cycles later.
- Wrap: RESET_PC=16'hFFF8, ready_in=1 -> pc_out sequence FFF8, FFFC, 0000, 0004.
- FETCH_EBREAK_HALT_EN defined with 32'h00100073 at address 8 -> pc_out 0, 4, 8, then valid_out=0, halted_out=1, rom_addr_out=0xC; redirect to 0 resumes. Without the macro, halted_out stays 0 and fetch continues at 0xC.
